fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/pipe_pkg.sv | 15 +
 rtl/fetch_skid_buf.sv | 39 +++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, bubble encoding and fetch FSM states
package pipe_pkg;

  localparam int          DEF_DATA_W   = 32;
  localparam int          DEF_PC_W     = 9;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {inst,pc} holding slot for a response that arrives while decode is stalled
module fetch_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PC_W   = DEF_PC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic              flush,
  input  logic [DATA_W-1:0] load_inst,
  input  logic [PC_W-1:0]   load_pc,
  output logic              valid,
  output logic [DATA_W-1:0] inst,
  output logic [PC_W-1:0]   pc
);

  // flush wins over load so a redirect in the same cycle never leaves a stale entry
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end

    if (rst) begin
      inst <= '0;
      pc   <= '0;
    end else if (load && !flush) begin
      inst <= load_inst;
      pc   <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with stall skid buffer and redirect squash
module fetch_unit
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                PC_W     = DEF_PC_W,
  parameter logic [DATA_W-1:0] NOP_INST = DEF_NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Pause,
  input  logic              Redirect,
  input  logic [PC_W-1:0]   RedirectPC,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] inst_out,
  output logic [PC_W-1:0]   opc,
  output logic              inst_valid
);

  fetch_state_t state, state_next;

  logic [PC_W-1:0]   pc, pc_next;
  logic [PC_W-1:0]   req_pc, req_pc_next;
  logic [DATA_W-1:0] inst_next;
  logic [PC_W-1:0]   opc_next;
  logic              valid_next;
  logic              consumed;

  logic              sb_load, sb_drain, sb_flush, sb_valid;
  logic [DATA_W-1:0] sb_inst;
  logic [PC_W-1:0]   sb_pc;

  assign consumed = inst_valid && !Pause;

  fetch_skid_buf #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (sb_load),
    .drain     (sb_drain),
    .flush     (sb_flush),
    .load_inst (imem_rdata),
    .load_pc   (req_pc),
    .valid     (sb_valid),
    .inst      (sb_inst),
    .pc        (sb_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    req_pc_next = req_pc;
    inst_next   = inst_out;
    opc_next    = opc;
    valid_next  = inst_valid;
    imem_req    = 1'b0;
    imem_addr   = pc;
    sb_load     = 1'b0;
    sb_drain    = 1'b0;
    sb_flush    = 1'b0;

    // a consumed slot becomes a bubble unless something below refills it
    if (consumed) begin
      valid_next = 1'b0;
      inst_next  = NOP_INST;
    end

    unique case (state)
      FETCH: begin
        imem_req    = !rst;
        req_pc_next = pc;
        pc_next     = pc + PC_W'(4);
        state_next  = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (!inst_valid || !Pause) begin
            inst_next  = imem_rdata;
            opc_next   = req_pc;
            valid_next = 1'b1;
            state_next = FETCH;
          end else begin
            sb_load    = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (!Pause) begin
          inst_next  = sb_inst;
          opc_next   = sb_pc;
          valid_next = sb_valid;
          sb_drain   = 1'b1;
          state_next = FETCH;
        end
      end
      DROP: begin
        if (imem_rvalid) state_next = FETCH;
      end
    endcase

    // a request still in flight after the redirect must be swallowed in DROP
    if (Redirect) begin
      pc_next    = RedirectPC & ~PC_W'(3);
      inst_next  = NOP_INST;
      opc_next   = opc;
      valid_next = 1'b0;
      sb_flush   = 1'b1;
      if ((state == FETCH) || (((state == WAIT) || (state == DROP)) && !imem_rvalid))
        state_next = DROP;
      else
        state_next = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      req_pc     <= '0;
      inst_out   <= NOP_INST;
      opc        <= '0;
      inst_valid <= 1'b0;
    end else begin
      pc         <= pc_next;
      req_pc     <= req_pc_next;
      inst_out   <= inst_next;
      opc        <= opc_next;
      inst_valid <= valid_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scenarios plus randomized stall/redirect traffic against a program-order scoreboard
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Pause = 1'b0;
  logic        Redirect = 1'b0;
  logic [8:0]  RedirectPC = '0;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst_out;
  logic [8:0]  opc;
  logic        inst_valid;

  int total = 0;
  int bad = 0;

  // memory model: one pending request, answered lat cycles after it is issued
  logic       pend = 1'b0;
  logic [8:0] pend_addr = '0;
  int         pend_cnt = 0;
  int         lat = 1;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .Pause       (Pause),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_out    (inst_out),
    .opc         (opc),
    .inst_valid  (inst_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [8:0] a);
    return 32'hAAAA_0000 + ({23'd0, a} >> 2) + 32'd1;
  endfunction

  // finish the current cycle (request capture), then move to the next negedge and drive the response
  task automatic cyc();
    #1;
    if (imem_req === 1'b1 && rst === 1'b0) begin
      total++;
      if (pend) begin
        bad++;
        $display("FAIL overlap: request at %h while %h still outstanding, required no second request", imem_addr, pend_addr);
      end
      pend = 1'b1;
      pend_addr = imem_addr;
      pend_cnt = lat;
    end
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata = mem_word(pend_addr);
        pend = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    Pause = 1'b0;
    Redirect = 1'b0;
    RedirectPC = '0;
    repeat (2) cyc();
    pend = 1'b0;
    imem_rvalid = 1'b0;
    rst = 1'b0;
    lat = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    Pause = 1'b1;
    Redirect = 1'b1;
    RedirectPC = 9'h080;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i > 0) begin
        total++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst_out !== NOP || opc !== 9'h000) begin
          bad++;
          $display("FAIL reset_state: req=%b valid=%b inst=%h opc=%h, required 0 0 %h 000", imem_req, inst_valid, inst_out, opc, NOP);
        end
      end
    end
    rst = 1'b0;
    Pause = 1'b0;
    Redirect = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 9'h000) begin
      bad++;
      $display("FAIL reset_first_req: req=%b addr=%h, required 1 000", imem_req, imem_addr);
    end
    cyc();
    pend = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    cyc();
    total++;
    if (inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_c1: valid=%b, required 0", inst_valid);
    end
    cyc();
    total++;
    if (inst_valid !== 1'b1 || opc !== 9'h000 || inst_out !== 32'hAAAA_0001) begin
      bad++;
      $display("FAIL basic_c2: valid=%b opc=%h inst=%h, required 1 000 aaaa0001", inst_valid, opc, inst_out);
    end
    cyc();
    cyc();
    total++;
    if (inst_valid !== 1'b1 || opc !== 9'h004 || inst_out !== 32'hAAAA_0002) begin
      bad++;
      $display("FAIL basic_c4: valid=%b opc=%h inst=%h, required 1 004 aaaa0002", inst_valid, opc, inst_out);
    end
  endtask

  task automatic test_pause();
    do_reset();
    cyc();
    cyc();
    Pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++;
      if (inst_valid !== 1'b1 || opc !== 9'h000 || inst_out !== 32'hAAAA_0001) begin
        bad++;
        $display("FAIL pause_hold[%0d]: valid=%b opc=%h inst=%h, required 1 000 aaaa0001", i, inst_valid, opc, inst_out);
      end
      if (i > 0) begin
        total++;
        if (imem_req !== 1'b0) begin
          bad++;
          $display("FAIL pause_noreq[%0d]: req=%b, required 0", i, imem_req);
        end
      end
    end
    Pause = 1'b0;
    cyc();
    total++;
    if (inst_valid !== 1'b1 || opc !== 9'h004 || inst_out !== 32'hAAAA_0002) begin
      bad++;
      $display("FAIL pause_release: valid=%b opc=%h inst=%h, required 1 004 aaaa0002", inst_valid, opc, inst_out);
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 9'h008) begin
      bad++;
      $display("FAIL pause_next_req: req=%b addr=%h, required 1 008", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    lat = 2;
    cyc();
    Redirect = 1'b1;
    RedirectPC = 9'h0A3;
    cyc();
    Redirect = 1'b0;
    total++;
    if (inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_wait_c2: valid=%b, required 0", inst_valid);
    end
    cyc();
    total++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 9'h0A0) begin
      bad++;
      $display("FAIL redir_wait_c3: valid=%b req=%b addr=%h, required 0 1 0a0", inst_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    #1;
    Redirect = 1'b1;
    RedirectPC = 9'h1FC;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 9'h000) begin
      bad++;
      $display("FAIL redir_fetch_req: req=%b addr=%h, required 1 000", imem_req, imem_addr);
    end
    cyc();
    Redirect = 1'b0;
    cyc();
    total++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 9'h1FC) begin
      bad++;
      $display("FAIL wrap_req_1fc: valid=%b req=%b addr=%h, required 0 1 1fc", inst_valid, imem_req, imem_addr);
    end
    cyc();
    cyc();
    total++;
    if (inst_valid !== 1'b1 || opc !== 9'h1FC || inst_out !== 32'hAAAA_0080 || imem_req !== 1'b1 || imem_addr !== 9'h000) begin
      bad++;
      $display("FAIL wrap_next: valid=%b opc=%h inst=%h req=%b addr=%h, required 1 1fc aaaa0080 1 000",
               inst_valid, opc, inst_out, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_pause();
    do_reset();
    cyc();
    cyc();
    Pause = 1'b1;
    cyc();
    cyc();
    total++;
    if (dut.u_skid.valid !== 1'b1 || inst_valid !== 1'b1) begin
      bad++;
      $display("FAIL rp_full: buf=%b valid=%b, required 1 1", dut.u_skid.valid, inst_valid);
    end
    Redirect = 1'b1;
    RedirectPC = 9'h040;
    cyc();
    Redirect = 1'b0;
    total++;
    if (inst_valid !== 1'b0 || inst_out !== NOP || dut.u_skid.valid !== 1'b0) begin
      bad++;
      $display("FAIL rp_squash: valid=%b inst=%h buf=%b, required 0 %h 0", inst_valid, inst_out, dut.u_skid.valid, NOP);
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 9'h040) begin
      bad++;
      $display("FAIL rp_req: req=%b addr=%h, required 1 040", imem_req, imem_addr);
    end
    Pause = 1'b0;
    cyc();
    cyc();
    total++;
    if (inst_valid !== 1'b1 || opc !== 9'h040 || inst_out !== mem_word(9'h040)) begin
      bad++;
      $display("FAIL rp_resume: valid=%b opc=%h inst=%h, required 1 040 %h", inst_valid, opc, inst_out, mem_word(9'h040));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 2;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    lat = 1;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 9'h000 || inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_first: req=%b addr=%h valid=%b, required 1 000 0", imem_req, imem_addr, inst_valid);
    end
    cyc();
    total++;
    if (inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_stale: valid=%b, required 0", inst_valid);
    end
    cyc();
    total++;
    if (inst_valid !== 1'b1 || opc !== 9'h000 || inst_out !== 32'hAAAA_0001) begin
      bad++;
      $display("FAIL rstmid_resp: valid=%b opc=%h inst=%h, required 1 000 aaaa0001", inst_valid, opc, inst_out);
    end
  endtask

  // every consumed instruction must be the next address in program order, reset by each redirect
  task automatic test_random();
    logic [8:0]  exp_pc;
    logic [31:0] prev_inst;
    logic [8:0]  prev_opc;
    logic        prev_hold;
    int          n_cons;
    do_reset();
    exp_pc = 9'h000;
    prev_hold = 1'b0;
    prev_inst = '0;
    prev_opc = '0;
    n_cons = 0;
    for (int c = 0; c < 3000; c++) begin
      lat = int'($urandom_range(1, 3));
      cyc();
      if (prev_hold) begin
        total++;
        if (inst_valid !== 1'b1 || inst_out !== prev_inst || opc !== prev_opc) begin
          bad++;
          $display("FAIL rand_stall_hold @%0d: valid=%b opc=%h inst=%h, required 1 %h %h", c, inst_valid, opc, inst_out, prev_opc, prev_inst);
        end
      end
      if (inst_valid === 1'b0) begin
        total++;
        if (inst_out !== NOP) begin
          bad++;
          $display("FAIL rand_bubble @%0d: inst=%h, required %h", c, inst_out, NOP);
        end
      end
      Pause = ($urandom_range(0, 2) == 0);
      Redirect = ($urandom_range(0, 24) == 0);
      RedirectPC = 9'($urandom);
      if (Redirect) begin
        exp_pc = RedirectPC & 9'h1FC;
      end else if (inst_valid === 1'b1 && !Pause) begin
        total++;
        if (opc !== exp_pc || inst_out !== mem_word(exp_pc)) begin
          bad++;
          $display("FAIL rand_order @%0d: opc=%h inst=%h, required %h %h", c, opc, inst_out, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 9'd4;
        n_cons++;
      end
      prev_hold = (inst_valid === 1'b1) && Pause && !Redirect;
      prev_inst = inst_out;
      prev_opc = opc;
    end
    Pause = 1'b0;
    Redirect = 1'b0;
    total++;
    if (n_cons < 200) begin
      bad++;
      $display("FAIL rand_progress: consumed=%0d, required at least 200", n_cons);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_redirect_wait();
    test_wrap();
    test_redirect_pause();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
